// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared FSM state encoding and digit limits for the stopwatch counter
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_t;

   localparam logic [3:0] ONES_MAX = 4'd9;
   localparam logic [2:0] TENS_MAX = 3'd5;

endpackage

// File: rtl/stopwatch_cnt_btn_cond.sv
// rtl/stopwatch_cnt_btn_cond.sv - button conditioner: 2-flop sync, optional debounce (STOPWATCH_DEBOUNCE_EN), rising-edge pulse
module btn_cond #(
   parameter int DEB_CYCLES = 1250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic press_p
);

   logic [1:0] sync_q;
   logic       level;
   logic       prev_q;

   // two-flop synchronizer for the asynchronous raw button
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], btn_raw};
      end
   end

`ifdef STOPWATCH_DEBOUNCE_EN
   localparam int DW = $clog2(DEB_CYCLES) + 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   logic [DW-1:0] deb_cnt_q;
   logic          stable_q;

   // accept a new level only after it has been sampled DEB_CYCLES times in a row
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_cnt_q <= '0;
         stable_q  <= 1'b0;
      end else if (sync_q[1] == stable_q) begin
         deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
         stable_q  <= sync_q[1];
         deb_cnt_q <= '0;
      end else begin
         deb_cnt_q <= deb_cnt_q + 1'b1;
      end
   end

   assign level = stable_q;
`else
   logic unused_deb_cfg;
   assign unused_deb_cfg = (DEB_CYCLES != 0);
   assign level = sync_q[1];
`endif

   // remember the previous accepted level for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= level;
      end
   end

   assign press_p = level & ~prev_q;

endmodule

// File: rtl/stopwatch_cnt.sv
// rtl/stopwatch_cnt.sv - 00..59 seconds stopwatch with start/pause and clear buttons; debounce via STOPWATCH_DEBOUNCE_EN
module stopwatch_cnt #(
   parameter int CLK_FREQ   = 125000000,
   parameter int DEB_CYCLES = 1250000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN_START,
   input  logic       BTN_CLR,
   output logic [3:0] NUM_1S,
   output logic [2:0] NUM_10S,
   output logic       RUNNING,
   output logic       WRAP
);

   import stopwatch_pkg::*;

   localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

   logic            start_p;
   logic            clr_p;
   sw_state_t       state_q;
   sw_state_t       state_d;
   logic [PW-1:0]   presc_q;
   logic            tick;
   logic [3:0]      ones_q;
   logic [2:0]      tens_q;
   logic            wrap_q;
   logic            running_q;

   btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_start_cond (
      .clk     (CLK),
      .rst_n   (RST),
      .btn_raw (BTN_START),
      .press_p (start_p)
   );

   btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_clr_cond (
      .clk     (CLK),
      .rst_n   (RST),
      .btn_raw (BTN_CLR),
      .press_p (clr_p)
   );

   // FSM state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state: clear dominates, start toggles between run and pause
   always_comb begin
      state_d = state_q;
      if (clr_p) begin
         state_d = IDLE;
      end else if (start_p) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

   // prescaler runs only in RUN, freezes in PAUSE, sits at zero otherwise
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         presc_q <= '0;
      end else if (clr_p) begin
         presc_q <= '0;
      end else begin
         case (state_q)
            RUN:     presc_q <= tick ? '0 : presc_q + 1'b1;
            PAUSE:   presc_q <= presc_q;
            default: presc_q <= '0;
         endcase
      end
   end

   // BCD seconds counter with a one-cycle wrap pulse on 59 -> 00
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ones_q <= 4'd0;
         tens_q <= 3'd0;
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         if (clr_p) begin
            ones_q <= 4'd0;
            tens_q <= 3'd0;
         end else if (tick) begin
            if (ones_q >= ONES_MAX) begin
               ones_q <= 4'd0;
               if (tens_q >= TENS_MAX) begin
                  tens_q <= 3'd0;
                  wrap_q <= 1'b1;
               end else begin
                  tens_q <= tens_q + 3'd1;
               end
            end else begin
               ones_q <= ones_q + 4'd1;
            end
         end
      end
   end

   // running flag registered alongside the state so it tracks RUN exactly
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         running_q <= 1'b0;
      end else begin
         running_q <= (state_d == RUN);
      end
   end

   assign NUM_1S  = ones_q;
   assign NUM_10S = tens_q;
   assign RUNNING = running_q;
   assign WRAP    = wrap_q;

endmodule

// File: doc/stopwatch_cnt.md
STOPWATCH_CNT -- requirements
Module: stopwatch_cnt

Interface
REQ-001 Parameter CLK_FREQ, default 125000000, input clock frequency in Hz; one count step every CLK_FREQ cycles.
REQ-002 Parameter DEB_CYCLES, default 1250000, number of stable cycles a button must hold before it is accepted.
REQ-003 CLK  input  1  system clock (125 MHz on board).
REQ-004 RST  input  1  reset, asynchronous, active-low; the block is in reset while RST = 0.
REQ-005 BTN_START  input  1  raw start/pause button, asynchronous, active-high.
REQ-006 BTN_CLR  input  1  raw clear button, asynchronous, active-high.
REQ-007 NUM_1S  output  4  seconds ones digit, range 0..9; feeds the 7-segment display stage.
REQ-008 NUM_10S  output  3  seconds tens digit, range 0..5; feeds the 7-segment display stage.
REQ-009 RUNNING  output  1  high while the FSM is in RUN.
REQ-010 WRAP  output  1  one-cycle pulse when the count rolls from 59 to 00.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer and then a rising-edge detector, producing a 1-cycle press pulse (start_p, clr_p).
REQ-012 FSM states SHALL be IDLE, RUN and PAUSE.
- IDLE: start_p -> RUN.
- RUN: start_p -> PAUSE.
- PAUSE: start_p -> RUN.
- Any state: clr_p -> IDLE.
REQ-013 If clr_p and start_p occur in the same cycle, clear SHALL win and the next state SHALL be IDLE.
REQ-014 Prescaler (width $clog2(CLK_FREQ)) SHALL count 0..CLK_FREQ-1 only in RUN, hold its value in PAUSE, and be 0 in IDLE.
REQ-015 tick SHALL be high for one cycle when the FSM is in RUN and the prescaler equals CLK_FREQ-1; the prescaler returns to 0 in the same cycle.
REQ-016 On tick, NUM_1S SHALL increment, with NUM_1S and NUM_10S updated on the clock edge that ends the tick cycle.
REQ-017 NUM_1S = 9 on tick SHALL give NUM_1S = 0 and NUM_10S + 1.
REQ-018 NUM_10S = 5 and NUM_1S = 9 on tick SHALL give 0/0 with WRAP = 1 for exactly that next cycle; counting then continues.
REQ-019 clr_p SHALL zero NUM_1S, NUM_10S and the prescaler on the next edge, overriding a coincident tick.
REQ-020 Outputs SHALL be registered, with no combinational path from button inputs to outputs.
REQ-021 NUM_1S SHALL never exceed 9, and NUM_10S SHALL never exceed 5.

Reset
REQ-022 While RST = 0, the block SHALL hold: FSM = IDLE, prescaler = 0, NUM_1S = 0, NUM_10S = 0, RUNNING = 0, WRAP = 0, synchronizer, edge-detector and debounce registers = 0.
REQ-023 Asserting reset mid-count SHALL take effect immediately, without waiting for CLK; after release, the block SHALL wait for a fresh BTN_START press.

Configuration
REQ-024 With macro STOPWATCH_DEBOUNCE_EN defined, each synchronized button SHALL feed a debounce counter, and the level SHALL be accepted only after DEB_CYCLES consecutive equal samples; the edge detector SHALL act on the accepted level.
REQ-025 Without STOPWATCH_DEBOUNCE_EN, the edge detector SHALL act directly on the synchronized level, and press latency SHALL be exactly 3 CLK edges from the input rising to the FSM state change.

Structure
REQ-026 Package stopwatch_pkg SHALL hold the FSM state encoding (IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2) and digit limits ONES_MAX = 9 and TENS_MAX = 5.
REQ-027 One sub-module, btn_cond, SHALL contain the synchronizer, the optional debounce and the edge detector; it SHALL be instantiated once per button.

Verification (CLK_FREQ = 5, DEB_CYCLES = 4, 10 ns clock)
REQ-028 The bench SHALL cover these directed scenarios:
- RST = 0 for 20 cycles, then released -> all outputs 0, FSM IDLE, no counting over 50 cycles.
- BTN_START pulse -> RUNNING = 1; NUM_1S steps 0, 1, 2 at 5-cycle intervals; after 10 ticks NUM_1S = 0, NUM_10S = 1.
- Run 60 ticks from 00 -> WRAP is high for exactly 1 cycle as the count goes 5/9 to 0/0.
- BTN_START in RUN at NUM_1S = 3, prescaler = 2 -> count holds 3 for 100 cycles; second press -> next tick arrives 3 cycles later.
- BTN_START and BTN_CLR rising together in RUN at 2/4 -> IDLE, count 0/0, RUNNING = 0.
- RST driven low mid-count at 3/7 -> outputs 0 with no clock edge; STOPWATCH_DEBOUNCE_EN build: a 2-cycle glitch on BTN_START produces no state change.
